// File: rtl/sram_arb.sv
// sram_arb: shares one single-clock sram among NUM_REQ requesters.
// One access (read or write) is granted per cycle. Write data is registered so
// it lines up with the sram's one-cycle-late wdata sampling. Read data is
// returned with a one-hot tag two cycles after the grant. The whole RAM can
// optionally be zero-filled after reset (CLEAR_ON_RESET).
// Build option: define SRAM_ARB_FIXED_PRIO_EN for fixed priority (lowest index
// wins) instead of the default round-robin arbitration.
module sram_arb #(
  parameter int NUM_REQ        = 2,
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 8,
  parameter int RAM_DEPTH      = 1 << ADDR_WIDTH,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          busy,
  output logic [ADDR_WIDTH-1:0]         s_radr,
  output logic                          s_ren,
  output logic [ADDR_WIDTH-1:0]         s_wadr,
  output logic                          s_wen,
  output logic [DATA_WIDTH-1:0]         s_wdata,
  input  logic [DATA_WIDTH-1:0]         s_rdata
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);
  localparam logic [PTR_W-1:0]      LAST_REQ  = PTR_W'(NUM_REQ - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t                  state_reg;
  logic [ADDR_WIDTH-1:0]   clr_cnt_reg;
  logic                    busy_reg;
  logic [DATA_WIDTH-1:0]   s_wdata_reg;
  logic [NUM_REQ-1:0]      rd_tag1_reg;
  logic [NUM_REQ-1:0]      rd_tag2_reg;

  logic [ADDR_WIDTH-1:0]   addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0]   wdata_arr [NUM_REQ];

  logic [PTR_W-1:0]        win_idx;
  logic                    win_vld;
  logic [PTR_W-1:0]        idx;
  logic                    run_ok;
  logic                    clear_ok;
  logic                    grant_any;
  logic                    grant_wr;
  logic                    grant_rd;

  // Unpack the per-requester buses and decode the one-hot grant
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign addr_arr[gi]  = addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_arr[gi] = wdata[gi*DATA_WIDTH +: DATA_WIDTH];
      assign gnt[gi]       = grant_any && (win_idx == PTR_W'(gi));
    end
  endgenerate

`ifdef SRAM_ARB_FIXED_PRIO_EN
  // Fixed priority: scan downward so the lowest requesting index is kept
  always_comb begin
    win_idx = '0;
    win_vld = 1'b0;
    idx     = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      idx = PTR_W'(j);
      if (req[idx]) begin
        win_idx = idx;
        win_vld = 1'b1;
      end
    end
  end
`else
  logic [PTR_W-1:0] rr_ptr_reg;
  logic [PTR_W:0]   sum;

  // Round-robin: scan offsets from the pointer downward so the smallest
  // offset (first requester at or after the pointer, wrapping) is kept
  always_comb begin
    win_idx = '0;
    win_vld = 1'b0;
    idx     = '0;
    sum     = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      sum = {1'b0, rr_ptr_reg} + (PTR_W+1)'(j);
      if (sum >= (PTR_W+1)'(NUM_REQ)) begin
        sum = sum - (PTR_W+1)'(NUM_REQ);
      end
      idx = sum[PTR_W-1:0];
      if (req[idx]) begin
        win_idx = idx;
        win_vld = 1'b1;
      end
    end
  end

  // Pointer advances past the winner on every grant, holds when idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_reg <= '0;
    end else if (grant_any) begin
      rr_ptr_reg <= (win_idx == LAST_REQ) ? '0 : win_idx + PTR_W'(1);
    end
  end
`endif

  // Grants and sram strobes are suppressed during reset and CLEAR
  always_comb begin
    run_ok    = !rst && (state_reg == ST_RUN);
    clear_ok  = !rst && (state_reg == ST_CLEAR);
    grant_any = run_ok && win_vld;
    grant_wr  = grant_any && we[win_idx];
    grant_rd  = grant_any && !we[win_idx];
  end

  assign s_ren   = grant_rd;
  assign s_radr  = addr_arr[win_idx];
  assign s_wen   = clear_ok || grant_wr;
  assign s_wadr  = (state_reg == ST_CLEAR) ? clr_cnt_reg : addr_arr[win_idx];
  assign s_wdata = s_wdata_reg;
  assign rdata   = s_rdata;
  assign rvalid  = rd_tag2_reg;
  assign busy    = busy_reg;

  // Control FSM: sweep every address once in CLEAR, then stay in RUN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      clr_cnt_reg <= '0;
      busy_reg    <= CLEAR_ON_RESET;
    end else begin
      case (state_reg)
        ST_CLEAR: begin
          clr_cnt_reg <= clr_cnt_reg + ADDR_WIDTH'(1);
          if (clr_cnt_reg == LAST_ADDR) begin
            state_reg <= ST_RUN;
            busy_reg  <= 1'b0;
          end
        end
        ST_RUN: begin
          busy_reg <= 1'b0;
        end
        default: begin
          state_reg <= ST_RUN;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // Write data lags the write strobe by one cycle; read tags follow the
  // sram's two-cycle read latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_wdata_reg <= '0;
      rd_tag1_reg <= '0;
      rd_tag2_reg <= '0;
    end else begin
      rd_tag1_reg <= grant_rd ? gnt : '0;
      rd_tag2_reg <= rd_tag1_reg;
      if (state_reg == ST_CLEAR) begin
        s_wdata_reg <= '0;
      end else if (grant_wr) begin
        s_wdata_reg <= wdata_arr[win_idx];
      end
    end
  end

endmodule

// File: tb/tb_sram_arb.sv
// tb_sram_arb: directed bench for sram_arb with a behavioural sram attached
// (two-cycle read latency, wdata sampled one cycle after wen/wadr).
// Expected values follow SRAM_ARB_FIXED_PRIO_EN if it is defined.
module tb_sram_arb;

  localparam int NR = 2;
  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req;
  logic [NR-1:0] we;
  logic [NR*AW-1:0] addr;
  logic [NR*DW-1:0] wdata;
  logic [NR-1:0] gnt;
  logic [NR-1:0] rvalid;
  logic [DW-1:0] rdata;
  logic          busy;
  logic [AW-1:0] s_radr;
  logic          s_ren;
  logic [AW-1:0] s_wadr;
  logic          s_wen;
  logic [DW-1:0] s_wdata;
  logic [DW-1:0] s_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_arb #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .RAM_DEPTH(16), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .busy(busy),
    .s_radr(s_radr), .s_ren(s_ren), .s_wadr(s_wadr), .s_wen(s_wen),
    .s_wdata(s_wdata), .s_rdata(s_rdata)
  );

  // Behavioural sram model
  logic [DW-1:0] mem [16];
  logic [AW-1:0] radr_q;
  logic [AW-1:0] wadr_q;
  logic          wen_q;
  logic [DW-1:0] rdata_q;
  logic          fill_mem;

  always @(posedge clk) begin
    if (s_ren) radr_q <= s_radr;
    rdata_q <= mem[radr_q];
    wen_q   <= s_wen;
    wadr_q  <= s_wadr;
    if (fill_mem) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'hFF;
    end else if (wen_q) begin
      mem[wadr_q] <= s_wdata;
    end
  end
  assign s_rdata = rdata_q;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [1:0] r, input logic [1:0] w,
                       input logic [3:0] a0, input logic [3:0] a1,
                       input logic [7:0] d0, input logic [7:0] d1);
    req   = r;
    we    = w;
    addr  = {a1, a0};
    wdata = {d1, d0};
    if (r != 2'b00)
      $display("txn t=%0t req=%b we=%b a0=%0h a1=%0h d0=%02h d1=%02h", $time, r, w, a0, a1, d0, d1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  logic [1:0] exp_g [6];
  int  busy_cnt;
  bit  gnt_seen;
  bit  done;

  initial begin
    rst      = 1'b1;
    fill_mem = 1'b1;
    drive(2'b11, 2'b00, 4'h1, 4'h2, 8'h00, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    fill_mem = 1'b0;
    settle();
    check_eq("rst_gnt",    gnt,     0);
    check_eq("rst_ren",    s_ren,   0);
    check_eq("rst_wen",    s_wen,   0);
    check_eq("rst_rvalid", rvalid,  0);
    check_eq("rst_wdata",  s_wdata, 0);
    check_eq("rst_busy",   busy,    1);

    // Test 1: CLEAR runs 16 cycles with no grants, then read addr 5
    rst = 1'b0;
    settle();
    check_eq("clr_wen",   s_wen,   1);
    check_eq("clr_wadr0", s_wadr,  0);
    check_eq("clr_wdata", s_wdata, 0);
    busy_cnt = 0;
    gnt_seen = 1'b0;
    done     = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      settle();
      if (busy) begin
        busy_cnt++;
        if (gnt != 2'b00) gnt_seen = 1'b1;
        step();
      end else begin
        drive(2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00);
        done = 1'b1;
      end
    end
    check_eq("clr_cycles", busy_cnt, 16);
    check_eq("clr_gnt",    gnt_seen, 0);

    drive(2'b01, 2'b00, 4'h5, 4'h0, 8'h00, 8'h00);
    settle();
    check_eq("t1_gnt",  gnt,    2'b01);
    check_eq("t1_ren",  s_ren,  1);
    check_eq("t1_radr", s_radr, 5);
    step();
    drive(2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00);
    settle();
    check_eq("t1_rvalid_k1", rvalid, 0);
    step();
    check_eq("t1_rvalid", rvalid, 2'b01);
    check_eq("t1_rdata",  rdata,  8'h00);

    // Test 2: write then immediate read of the same address
    drive(2'b01, 2'b01, 4'h3, 4'h0, 8'hA5, 8'h00);
    settle();
    check_eq("t2_gnt",   gnt,    2'b01);
    check_eq("t2_wen",   s_wen,  1);
    check_eq("t2_wadr",  s_wadr, 3);
    check_eq("t2_ren",   s_ren,  0);
    step();
    check_eq("t2_wdata", s_wdata, 8'hA5);
    drive(2'b01, 2'b00, 4'h3, 4'h0, 8'h00, 8'h00);
    settle();
    check_eq("t2_rd_ren", s_ren, 1);
    step();
    drive(2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00);
    settle();
    check_eq("idle_ren",  s_ren,  0);
    check_eq("idle_wen",  s_wen,  0);
    check_eq("idle_gnt",  gnt,    0);
    check_eq("t2_rvalid_k2", rvalid, 0);
    step();
    check_eq("t2_rvalid", rvalid, 2'b01);
    check_eq("t2_rdata",  rdata,  8'hA5);

    // Preload addr 0..3 with 0x10..0x13 through requester 1
    for (int i = 0; i < 4; i++) begin
      drive(2'b10, 2'b10, 4'h0, 4'(i), 8'h00, 8'(8'h10 + i));
      settle();
      check_eq("pre_gnt", gnt, 2'b10);
      step();
    end

    // Test 5: back-to-back reads of addr 0..3
    for (int i = 0; i < 6; i++) begin
      if (i < 4) drive(2'b01, 2'b00, 4'(i), 4'h0, 8'h00, 8'h00);
      else       drive(2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00);
      settle();
      if (i < 4) check_eq("t5_gnt", gnt, 2'b01);
      if (i >= 2) begin
        check_eq("t5_rvalid", rvalid, 2'b01);
        check_eq("t5_rdata",  rdata,  8'(8'h10 + i - 2));
      end else begin
        check_eq("t5_rvalid_lead", rvalid, 0);
      end
      step();
    end

    // Write addr 4 = 0x14 via requester 1 (pointer then points at 0)
    drive(2'b10, 2'b10, 4'h0, 4'h4, 8'h00, 8'h14);
    settle();
    check_eq("w4_gnt", gnt, 2'b10);
    step();

    // Tests 3/4: both requesters reading continuously
`ifdef SRAM_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 6; i++) exp_g[i] = 2'b01;
`else
    for (int i = 0; i < 6; i++) exp_g[i] = (i % 2 == 0) ? 2'b01 : 2'b10;
`endif
    for (int i = 0; i < 8; i++) begin
      if (i < 6) drive(2'b11, 2'b00, 4'h3, 4'h4, 8'h00, 8'h00);
      else       drive(2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00);
      settle();
      if (i < 6) check_eq("t3_gnt", gnt, exp_g[i]);
      if (i >= 2) begin
        check_eq("t3_rvalid", rvalid, exp_g[i-2]);
        check_eq("t3_rdata",  rdata,  (exp_g[i-2] == 2'b01) ? 8'h13 : 8'h14);
      end
      step();
    end
    drive(2'b10, 2'b00, 4'h0, 4'h4, 8'h00, 8'h00);
    settle();
    check_eq("t4_gnt_r1", gnt, 2'b10);
    step();
    drive(2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00);
    step();
    check_eq("t4_rvalid", rvalid, 2'b10);
    check_eq("t4_rdata",  rdata,  8'h14);

    // Test 6: reset one cycle after a read grant
    drive(2'b01, 2'b00, 4'h3, 4'h0, 8'h00, 8'h00);
    settle();
    check_eq("t6_gnt", gnt, 2'b01);
    step();
    drive(2'b00, 2'b00, 4'h0, 4'h0, 8'h00, 8'h00);
    rst = 1'b1;
    settle();
    check_eq("t6_rvalid_rst", rvalid, 0);
    check_eq("t6_busy_rst",   busy,   1);
    check_eq("t6_wen_rst",    s_wen,  0);
    step();
    check_eq("t6_rvalid_k2", rvalid, 0);
    step();
    rst = 1'b0;
    settle();
    check_eq("t6_busy",  busy,   1);
    check_eq("t6_wen",   s_wen,  1);
    check_eq("t6_wadr0", s_wadr, 0);
    step();
    check_eq("t6_wadr1", s_wadr, 1);
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (!busy) done = 1'b1;
      else step();
    end
    check_eq("t6_clr_done", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
